lampfpu_sqrt_ctrl: RTL and testbench



---
 rtl/lampfpu_sqrt_ctrl_pkg.sv | 18 +
 rtl/lampfpu_sqrt_round.sv | 29 ++
 rtl/lampfpu_sqrt_ctrl.sv | 148 ++++++++++++++
 tb/tb_lampfpu_sqrt_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lampfpu_sqrt_ctrl_pkg.sv
// Shared lampFPU constants and the square-root controller state encoding.
package lampFPU_pkg;
  localparam int LAMP_FLOAT_DW     = 16;
  localparam int LAMP_FLOAT_E_DW   = 8;
  localparam int LAMP_FLOAT_F_DW   = 7;
  localparam int LAMP_FLOAT_E_BIAS = 127;

  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_QNAN = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_INF  = 16'h7F80;

  typedef enum logic [2:0] {
    SQRT_IDLE,
    SQRT_ISSUE,
    SQRT_WAIT,
    SQRT_NORM,
    SQRT_DONE
  } sqrtCtrlState_t;
endpackage

// File: rtl/lampfpu_sqrt_round.sv
// Normalise the Q0.16 core root, round to nearest-even and pack a positive float.
module lampfpu_sqrt_round
  import lampFPU_pkg::*;
(
  input  logic [15:0] r_i,
  input  logic [7:0]  k_i,
  output logic [15:0] res_o
);
  logic [6:0] frac;
  logic       guard, sticky;
  logic [7:0] exp_b, fsum;

  always_comb begin
    frac   = r_i[13:7];
    guard  = r_i[6];
    sticky = |r_i[5:0];
    exp_b  = 8'(LAMP_FLOAT_E_BIAS - 2) + k_i;
    if (r_i[15]) begin
      frac   = r_i[14:8];
      guard  = r_i[7];
      sticky = |r_i[6:0];
      exp_b  = 8'(LAMP_FLOAT_E_BIAS - 1) + k_i;
    end
    // A carry out of the fraction leaves fsum[6:0] at zero and bumps the exponent.
    fsum  = {1'b0, frac} + {7'b0, guard & (sticky | frac[0])};
    res_o = {1'b0, exp_b + {7'b0, fsum[7]}, fsum[6:0]};
    if (r_i[15:14] == 2'b00) res_o = '0;
  end
endmodule

// File: rtl/lampfpu_sqrt_ctrl.sv
// Square-root operation controller: special operands, core handshake, result packing.
// Optional core watchdog enabled by defining LAMP_SQRT_TIMEOUT_EN.
module lampfpu_sqrt_ctrl
  import lampFPU_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        doSqrt_i,
  input  logic [15:0] op_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [15:0] res_o,
  output logic        isInv_o,
  output logic        isTo_o,
  output logic        core_doSqrt_o,
  output logic [7:0]  core_s_o,
  input  logic        core_valid_i,
  input  logic [15:0] core_res_i
);
  sqrtCtrlState_t state_q;
  logic        busy_q, valid_q, inv_q, core_do_q;
  logic [15:0] res_q, r_q, norm_res;
  logic [7:0]  core_s_q, k_q;

  logic        op_sign, is_nan, is_neg, is_inf, is_zero, is_special;
  logic [7:0]  op_exp, e8, k_d, s_d;
  logic [6:0]  op_frac;
  logic [15:0] spec_res;
  logic        spec_inv;

  always_comb begin
    op_sign  = op_i[15];
    op_exp   = op_i[14:7];
    op_frac  = op_i[6:0];
    is_nan   = (op_exp == 8'hFF) && (op_frac != '0);
    is_neg   = op_sign && ((op_exp != '0) || (op_frac != '0));
    is_inf   = (op_exp == 8'hFF);
    is_zero  = (op_exp == 8'h00);
    is_special = is_nan || is_neg || is_inf || is_zero;
    spec_inv = 1'b0;
    spec_res = {op_sign, 15'b0};
    if (is_nan) spec_res = LAMP_FLOAT_QNAN;
    else if (is_neg) begin
      spec_res = LAMP_FLOAT_QNAN;
      spec_inv = 1'b1;
    end else if (is_inf) spec_res = LAMP_FLOAT_INF;
    // k = e/2+1 for even e and (e+3)/2 = floor(e/2)+2 for odd e, in 8 signed bits.
    e8  = op_exp - 8'(LAMP_FLOAT_E_BIAS);
    k_d = 8'($signed(e8) >>> 1) + (e8[0] ? 8'd2 : 8'd1);
    s_d = e8[0] ? {2'b00, 1'b1, op_frac[6:2]} : {1'b0, 1'b1, op_frac[6:1]};
  end

  lampfpu_sqrt_round u_round (.r_i(r_q), .k_i(k_q), .res_o(norm_res));

`ifdef LAMP_SQRT_TIMEOUT_EN
  logic [5:0] cnt_q;
  logic       to_q;
  assign isTo_o = to_q;
`else
  assign isTo_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SQRT_IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      res_q     <= '0;
      inv_q     <= 1'b0;
      core_do_q <= 1'b0;
      core_s_q  <= '0;
      k_q       <= '0;
      r_q       <= '0;
`ifdef LAMP_SQRT_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      valid_q   <= 1'b0;
      core_do_q <= 1'b0;
      case (state_q)
        SQRT_IDLE, SQRT_DONE: begin
          state_q <= SQRT_IDLE;
          busy_q  <= 1'b0;
          if (doSqrt_i) begin
            if (is_special) begin
              state_q <= SQRT_DONE;
              valid_q <= 1'b1;
              res_q   <= spec_res;
              inv_q   <= spec_inv;
`ifdef LAMP_SQRT_TIMEOUT_EN
              to_q    <= 1'b0;
`endif
            end else begin
              state_q   <= SQRT_ISSUE;
              busy_q    <= 1'b1;
              core_do_q <= 1'b1;
              core_s_q  <= s_d;
              k_q       <= k_d;
            end
          end
        end
        SQRT_ISSUE: begin
          state_q <= SQRT_WAIT;
`ifdef LAMP_SQRT_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        SQRT_WAIT: begin
          if (core_valid_i) begin
            r_q     <= core_res_i;
            state_q <= SQRT_NORM;
          end
`ifdef LAMP_SQRT_TIMEOUT_EN
          else if (cnt_q == 6'(TIMEOUT_CYCLES - 1)) begin
            state_q <= SQRT_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            res_q   <= LAMP_FLOAT_QNAN;
            inv_q   <= 1'b0;
            to_q    <= 1'b1;
          end else cnt_q <= cnt_q + 6'd1;
`endif
        end
        SQRT_NORM: begin
          state_q <= SQRT_DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          res_q   <= norm_res;
          inv_q   <= 1'b0;
`ifdef LAMP_SQRT_TIMEOUT_EN
          to_q    <= 1'b0;
`endif
        end
        default: state_q <= SQRT_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign valid_o       = valid_q;
  assign res_o         = res_q;
  assign isInv_o       = inv_q;
  assign core_doSqrt_o = core_do_q;
  assign core_s_o      = core_s_q;
endmodule

// File: tb/tb_lampfpu_sqrt_ctrl.sv
// Directed bench for lampfpu_sqrt_ctrl; the core is modelled by hand-timed strobes.
module tb_lampfpu_sqrt_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        doSqrt_i = 1'b0, core_valid_i = 1'b0;
  logic [15:0] op_i = '0, core_res_i = '0;
  logic        busy_o, valid_o, isInv_o, isTo_o, core_doSqrt_o;
  logic [15:0] res_o;
  logic [7:0]  core_s_o;
  int checks = 0, failures = 0;

  lampfpu_sqrt_ctrl #(.TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .doSqrt_i(doSqrt_i), .op_i(op_i),
    .busy_o(busy_o), .valid_o(valid_o), .res_o(res_o), .isInv_o(isInv_o),
    .isTo_o(isTo_o), .core_doSqrt_o(core_doSqrt_o), .core_s_o(core_s_o),
    .core_valid_i(core_valid_i), .core_res_i(core_res_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [15:0] op);
    op_i = op; doSqrt_i = 1'b1; step(); doSqrt_i = 1'b0;
  endtask

  task automatic core_ret(input logic [15:0] r);
    core_valid_i = 1'b1; core_res_i = r; step(); core_valid_i = 1'b0;
  endtask

  logic [15:0] sp_op  [4] = '{16'hC000, 16'h7F80, 16'h8000, 16'h7FC1};
  logic [15:0] sp_res [4] = '{16'h7FC0, 16'h7F80, 16'h8000, 16'h7FC0};
  logic        sp_inv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #3;
    chk("rst_busy", 16'(busy_o), 16'd0);
    chk("rst_valid", 16'(valid_o), 16'd0);
    chk("rst_res", res_o, 16'h0000);
    chk("rst_inv", 16'(isInv_o), 16'd0);
    chk("rst_to", 16'(isTo_o), 16'd0);
    chk("rst_cdo", 16'(core_doSqrt_o), 16'd0);
    chk("rst_cs", 16'(core_s_o), 16'h00);
    step(); rst = 1'b0; step();

    // 4.0: root 0.5 from the core after 5 cycles
    start(16'h4080);
    chk("t4_cdo", 16'(core_doSqrt_o), 16'd1);
    chk("t4_cs", 16'(core_s_o), 16'h40);
    chk("t4_busy", 16'(busy_o), 16'd1);
    step();
    chk("t4_cdo_pulse", 16'(core_doSqrt_o), 16'd0);
    repeat (4) step();
    core_ret(16'h8000);
    chk("t4_norm_valid", 16'(valid_o), 16'd0);
    step();
    chk("t4_valid", 16'(valid_o), 16'd1);
    chk("t4_res", res_o, 16'h4000);
    chk("t4_busy_done", 16'(busy_o), 16'd0);
    step();
    chk("t4_valid_pulse", 16'(valid_o), 16'd0);
    chk("t4_res_hold", res_o, 16'h4000);

    // 2.0: odd exponent path
    start(16'h4000);
    chk("t2_cs", 16'(core_s_o), 16'h20);
    step(); step();
    core_ret(16'h5A82);
    step();
    chk("t2_valid", 16'(valid_o), 16'd1);
    chk("t2_res", res_o, 16'h3FB5);
    chk("t2_inv", 16'(isInv_o), 16'd0);
    step();

    for (int i = 0; i < 4; i++) begin
      start(sp_op[i]);
      chk("sp_valid", 16'(valid_o), 16'd1);
      chk("sp_res", res_o, sp_res[i]);
      chk("sp_inv", 16'(isInv_o), 16'(sp_inv[i]));
      chk("sp_cdo", 16'(core_doSqrt_o), 16'd0);
      chk("sp_busy", 16'(busy_o), 16'd0);
      step();
    end

    // 1.0 with round-up carry; drop in WAIT, accept in DONE
    start(16'h3F80);
    chk("t1_cs", 16'(core_s_o), 16'h40);
    step();
    op_i = 16'hC000; doSqrt_i = 1'b1; step(); doSqrt_i = 1'b0;
    chk("drop_busy", 16'(busy_o), 16'd1);
    chk("drop_valid", 16'(valid_o), 16'd0);
    core_ret(16'h7FFF);
    step();
    chk("t1_valid", 16'(valid_o), 16'd1);
    chk("t1_res", res_o, 16'h3F80);
    chk("t1_inv", 16'(isInv_o), 16'd0);
    start(16'h7F80);
    chk("done_acc_valid", 16'(valid_o), 16'd1);
    chk("done_acc_res", res_o, 16'h7F80);
    step();

    // silent core: watchdog or indefinite wait
    start(16'h4080);
`ifdef LAMP_SQRT_TIMEOUT_EN
    repeat (32) step();
    chk("to_early", 16'(valid_o), 16'd0);
    step();
    chk("to_valid", 16'(valid_o), 16'd1);
    chk("to_res", res_o, 16'h7FC0);
    chk("to_flag", 16'(isTo_o), 16'd1);
    step();
    core_ret(16'h8000);
    step();
    chk("to_late_valid", 16'(valid_o), 16'd0);
    chk("to_late_res", res_o, 16'h7FC0);
`else
    repeat (40) step();
    chk("wait_busy", 16'(busy_o), 16'd1);
    chk("wait_valid", 16'(valid_o), 16'd0);
    chk("wait_to", 16'(isTo_o), 16'd0);
    core_ret(16'h8000);
    step();
    chk("wait_res", res_o, 16'h4000);
    step();
`endif

    // async reset mid-WAIT
    start(16'h4000);
    step(); step();
    #2 rst = 1'b1; #1;
    chk("arst_busy", 16'(busy_o), 16'd0);
    chk("arst_res", res_o, 16'h0000);
    chk("arst_cs", 16'(core_s_o), 16'h00);
    chk("arst_flags", {14'd0, isInv_o, isTo_o}, 16'd0);
    #1 rst = 1'b0;
    step();
    core_ret(16'h5A82);
    step();
    chk("arst_ign_valid", 16'(valid_o), 16'd0);
    chk("arst_ign_busy", 16'(busy_o), 16'd0);
    step();
    chk("arst_ign_res", res_o, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
